// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch unit: NPCOp codes, fetch FSM states and a
// branch-offset helper.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JR     = 3'd3,
    NPC_EXCEPT = 3'd4
  } npc_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_EXEC = 2'd3
  } fetch_state_e;

  // Word offset of a 16-bit branch immediate, sign-extended to a byte offset.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    logic signed [31:0] ext;
    ext = 32'(signed'(imm));
    return ext <<< 2;
  endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC selection from the resolved NPCOp; misaligned JR
// targets are redirected to the exception vector.
module npc_calc
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [2:0]  npc_op,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0]        pc_plus4;
  logic signed [31:0] br_target;
  logic [5:0]         unused_opcode;

  assign unused_opcode = instr[31:26];
  assign pc_plus4      = pc + 32'd4;
  assign br_target     = signed'(pc_plus4) + branch_offset(instr[15:0]);
  assign misalign      = (npc_op == NPC_JR) && (rs_data[1:0] != 2'b00);

  always_comb begin
    next_pc = EXC_VECTOR;
    case (npc_op)
      NPC_PLUS4:  next_pc = pc_plus4;
      NPC_BRANCH: next_pc = unsigned'(br_target);
      NPC_JUMP:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      NPC_JR:     next_pc = misalign ? EXC_VECTOR : rs_data;
      default:    next_pc = EXC_VECTOR;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch / PC sequencer. Define FETCH_TIMEOUT_EN to
// abandon a fetch after TIMEOUT_CYCLES without imem_ack.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_4180,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic [2:0]  npc_op,
  input  logic [31:0] rs_data,
  output logic        addr_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         vld_q, vld_d;
  logic         aerr_q, aerr_d;
  logic [31:0]  next_pc;
  logic         misalign;

  npc_calc #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_npc_calc (
    .pc      (pc_q),
    .instr   (instr_q),
    .rs_data (rs_data),
    .npc_op  (npc_op),
    .next_pc (next_pc),
    .misalign(misalign)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  // cnt_q counts completed request cycles, so the last allowed cycle is N-1.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    aerr_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_REQ, S_WAIT: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          vld_d   = 1'b1;
          state_d = S_EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) begin
          aerr_d  = 1'b1;
          pc_d    = EXC_VECTOR;
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_WAIT;
        end
`else
        else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_EXEC: begin
        if (exec_done) begin
          vld_d   = 1'b0;
          pc_d    = next_pc;
          aerr_d  = misalign;
          state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      vld_q   <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      aerr_q  <= aerr_d;
    end
  end

  // Request is decoded from state so an async reset drops it immediately.
  assign imem_req    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = vld_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign addr_err    = aerr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, sequential/branch/jump/JR flow,
// handshake stalls, ignored strobes and reset during a pending fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic [2:0]  npc_op;
  logic [31:0] rs_data;
  logic        addr_err;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2:0] OP_PLUS4 = 3'd0;
  localparam logic [2:0] OP_BR    = 3'd1;
  localparam logic [2:0] OP_J     = 3'd2;
  localparam logic [2:0] OP_JR    = 3'd3;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .exec_done  (exec_done),
    .npc_op     (npc_op),
    .rs_data    (rs_data),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its address, ack it at once.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
    int n = 0;
    while (!imem_req && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    check({tag, "_vld"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instr, word);
  endtask

  // Complete the current instruction; the next state is S_REQ at next_pc.
  task automatic execute(input logic [2:0] op, input logic [31:0] rs);
    exec_done = 1'b1;
    npc_op    = op;
    rs_data   = rs;
    tick();
    exec_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; npc_op = OP_PLUS4; rs_data = '0;
    tick(); tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, 32'h3000);
    check("rst_vld", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_aerr", 32'(addr_err), 32'd0);

    rst = 1'b0;
    check("idle_req", 32'(imem_req), 32'd0);
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h3000);

    // Sequential flow
    fetch("f3000", 32'h3000, 32'h0000_0000);
    check("pc_plus4", pc_plus4, 32'h3004);
    execute(OP_PLUS4, 0);
    check("vld_clr", 32'(instr_valid), 32'd0);
    fetch("f3004", 32'h3004, 32'h0000_0001); execute(OP_PLUS4, 0);
    fetch("f3008", 32'h3008, 32'h0000_0002); execute(OP_PLUS4, 0);
    fetch("f300c", 32'h300C, 32'h0000_0003); execute(OP_PLUS4, 0);

    // Branches: negative, small positive, then back-to-0x3010 forward
    fetch("br_neg", 32'h3010, 32'h1000_FFFC); execute(OP_BR, 0);
    fetch("br_p2", 32'h3004, 32'h1000_0002);  execute(OP_BR, 0);
    fetch("br_p3", 32'h3010, 32'h1000_0003);  execute(OP_BR, 0);

    // Jumps and JR
    fetch("j_a", 32'h3020, 32'h0800_0C00); execute(OP_J, 0);
    fetch("j_b", 32'h3000, 32'h0800_0C10); execute(OP_J, 0);
    fetch("jr_ok", 32'h3040, 32'h03E0_0008); execute(OP_JR, 32'h3100);
    check("jr_ok_aerr", 32'(addr_err), 32'd0);
    fetch("jr_bad", 32'h3100, 32'h03E0_0008); execute(OP_JR, 32'h3102);
    check("jr_bad_aerr", 32'(addr_err), 32'd1);
    check("jr_bad_addr", imem_addr, 32'h4180);
    tick();
    check("aerr_pulse", 32'(addr_err), 32'd0);
    fetch("exc7", 32'h4180, 32'h0); execute(3'd7, 0);
    fetch("exc4", 32'h4180, 32'h0); execute(3'd4, 0);

    // Wrap-around of the PC
    fetch("wrap_a", 32'h4180, 32'h0); execute(OP_JR, 32'hFFFF_FFFC);
    fetch("wrap_b", 32'hFFFF_FFFC, 32'h0); execute(OP_PLUS4, 0);

    // Stall: ack held off 5 cycles, exec_done during S_WAIT ignored
    check("stall_req0", 32'(imem_req), 32'd1);
    check("stall_addr0", imem_addr, 32'h0);
    exec_done = 1'b1; npc_op = OP_JR; rs_data = 32'h5000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", imem_addr, 32'h0);
      check("stall_vld", 32'(instr_valid), 32'd0);
    end
    exec_done = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001;
    check("stall_vld_ack", 32'(instr_valid), 32'd0);
    tick();
    imem_ack = 1'b0;
    check("stall_vld_rise", 32'(instr_valid), 32'd1);
    check("stall_instr", instr, 32'hCAFE_0001);

    // Spurious ack in S_EXEC
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("spur_instr", instr, 32'hCAFE_0001);
    check("spur_req", 32'(imem_req), 32'd0);
    check("spur_vld", 32'(instr_valid), 32'd1);
    execute(OP_JR, 32'h3008);

    // Reset while waiting at 0x3008
    check("mid_addr", imem_addr, 32'h3008);
    tick();
    check("mid_wait_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_pc", pc, 32'h3000);
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("late_ack_vld", 32'(instr_valid), 32'd0);
    check("late_ack_instr", instr, 32'h0);
    check("late_req", 32'(imem_req), 32'd1);
    check("late_addr", imem_addr, 32'h3000);

`ifdef FETCH_TIMEOUT_EN
    begin
      int cyc = 0;
      while (!addr_err && cyc < 40) begin
        tick();
        cyc++;
      end
      check("to_cycles", 32'(cyc), 32'd16);
      check("to_addr", imem_addr, 32'h4180);
      check("to_req", 32'(imem_req), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
